lab1_key_debounce: RTL and testbench

Multi-channel synchronizer and debouncer for raw push-button and slide-switch inputs. It sits directly upstream of the Avalon edge-capture PIO and drives that PIO's 8-bit `in_port`. The PIO therefore sees only clean, glitch-free level changes, and each physical press raises exactly one edge-capture event. Per-channel one-cycle rise and fall strobes are also exported for fabric logic that does not go through the PIO.

---
 rtl/lab1_debounce_pkg.sv | 14 +
 rtl/lab1_debounce_chan.sv | 89 ++++++++
 rtl/lab1_key_debounce.sv | 29 ++
 tb/tb_lab1_key_debounce.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lab1_debounce_pkg.sv
// rtl/lab1_debounce_pkg.sv - shared state encodings and counter sizing for the key debouncer
package lab1_debounce_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } state_t;

    // Width needed to hold values 0..n
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/lab1_debounce_chan.sv
// rtl/lab1_debounce_chan.sv - one channel: 2-FF synchronizer, debounce FSM/counter, edge strobes
module lab1_debounce_chan
    import lab1_debounce_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = 500000,
    parameter logic RESET_BIT       = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in_raw,
    output logic db_out,
    output logic rise,
    output logic fall
);

    localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1;
    logic          s2;
    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          db_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= RESET_BIT;
            s2 <= RESET_BIT;
        end else begin
            s1 <= in_raw;
            s2 <= s1;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        db_nxt    = db_out;
        case (state)
            ST_IDLE: begin
                if (s2 != db_out) begin
                    // A single-cycle debounce accepts the change without counting
                    if (DEBOUNCE_CYCLES == 1) begin
                        db_nxt = ~db_out;
                    end else begin
                        state_nxt = ST_COUNT;
                        cnt_nxt   = CNT_ONE;
                    end
                end
            end
            ST_COUNT: begin
                if (s2 == db_out) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    db_nxt    = ~db_out;
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            db_out <= RESET_BIT;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            db_out <= db_nxt;
            rise   <= db_nxt & ~db_out;
            fall   <= ~db_nxt & db_out;
        end
    end

endmodule

// File: rtl/lab1_key_debounce.sv
// rtl/lab1_key_debounce.sv - multi-channel key/switch debouncer feeding the edge-capture PIO
module lab1_key_debounce #(
    parameter int               WIDTH           = 8,
    parameter int               DEBOUNCE_CYCLES = 500000,
    parameter logic [WIDTH-1:0] RESET_LEVEL     = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_raw,
    output logic [WIDTH-1:0] db_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        lab1_debounce_chan #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .RESET_BIT      (RESET_LEVEL[i])
        ) u_chan (
            .clk    (clk),
            .reset_n(reset_n),
            .in_raw (in_raw[i]),
            .db_out (db_out[i]),
            .rise   (rise[i]),
            .fall   (fall[i])
        );
    end

endmodule

// File: tb/tb_lab1_key_debounce.sv
// tb/tb_lab1_key_debounce.sv - scoreboard bench for lab1_key_debounce with DEBOUNCE_CYCLES=4
module tb_lab1_key_debounce;

    localparam int D = 4;

    typedef struct packed {
        logic [31:0] edge_n;
        logic [7:0]  db;
        logic [7:0]  rise;
        logic [7:0]  fall;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] in_raw;
    logic [7:0] db_out;
    logic [7:0] rise;
    logic [7:0] fall;

    int   checks = 0;
    int   errors = 0;
    int   edge_cnt = 0;
    ev_t  exp_q[$];
    ev_t  obs_q[$];

    lab1_key_debounce #(
        .WIDTH          (8),
        .DEBOUNCE_CYCLES(D),
        .RESET_LEVEL    (8'hFF)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .in_raw (in_raw),
        .db_out (db_out),
        .rise   (rise),
        .fall   (fall)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    always @(negedge clk) begin
        if (rise != 8'h00 || fall != 8'h00)
            obs_q.push_back('{edge_n: edge_cnt, db: db_out, rise: rise, fall: fall});
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Expected event relative to the first sampling edge of a change driven now
    task automatic expect_ev(input int k, input int lat, input logic [7:0] db,
                             input logic [7:0] r, input logic [7:0] f);
        exp_q.push_back('{edge_n: k + lat, db: db, rise: r, fall: f});
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        in_raw  = 8'h00;
        cycles(3);
        checks++;
        if (db_out !== 8'hFF) begin
            errors++;
            $display("FAIL reset_db: got %h expected ff", db_out);
        end
        checks++;
        if (rise !== 8'h00) begin
            errors++;
            $display("FAIL reset_rise: got %h expected 00", rise);
        end
        checks++;
        if (fall !== 8'h00) begin
            errors++;
            $display("FAIL reset_fall: got %h expected 00", fall);
        end
        in_raw = 8'hFF;
        cycles(1);
        reset_n = 1'b1;
        obs_q.delete();
        cycles(20);
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL reset_idle_strobes: got %0d events expected 0", obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_clean_press();
        ev_t e;
        ev_t o;
        expect_ev(edge_cnt + 1, D + 1, 8'hFE, 8'h00, 8'h01);
        in_raw[0] = 1'b0;
        cycles(10);
        checks++;
        if (db_out !== 8'hFE) begin
            errors++;
            $display("FAIL press_level: got %h expected fe", db_out);
        end
        expect_ev(edge_cnt + 1, D + 1, 8'hFF, 8'h01, 8'h00);
        in_raw[0] = 1'b1;
        cycles(10);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL clean_press_missing: got none expected edge %0d db %h rise %h fall %h",
                         e.edge_n, e.db, e.rise, e.fall);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL clean_press_event: got edge %0d db %h rise %h fall %h expected edge %0d db %h rise %h fall %h",
                             o.edge_n, o.db, o.rise, o.fall, e.edge_n, e.db, e.rise, e.fall);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL clean_press_extra: got %0d extra events expected 0", obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_glitch();
        in_raw[1] = 1'b0;
        cycles(D - 1);
        in_raw[1] = 1'b1;
        cycles(15);
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL glitch_strobes: got %0d events expected 0", obs_q.size());
        end
        checks++;
        if (db_out !== 8'hFF) begin
            errors++;
            $display("FAIL glitch_level: got %h expected ff", db_out);
        end
        obs_q.delete();
    endtask

    task automatic test_bounce();
        ev_t e;
        ev_t o;
        for (int i = 0; i < 6; i++) begin
            in_raw[2] = i[0];
            cycles(2);
        end
        expect_ev(edge_cnt + 1, D + 1, 8'hFB, 8'h00, 8'h04);
        in_raw[2] = 1'b0;
        cycles(12);
        expect_ev(edge_cnt + 1, D + 1, 8'hFF, 8'h04, 8'h00);
        in_raw[2] = 1'b1;
        cycles(10);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL bounce_missing: got none expected edge %0d db %h rise %h fall %h",
                         e.edge_n, e.db, e.rise, e.fall);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL bounce_event: got edge %0d db %h rise %h fall %h expected edge %0d db %h rise %h fall %h",
                             o.edge_n, o.db, o.rise, o.fall, e.edge_n, e.db, e.rise, e.fall);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL bounce_extra: got %0d extra events expected 0", obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_independence();
        ev_t e;
        ev_t o;
        int  k;
        k = edge_cnt + 1;
        expect_ev(k, D + 1, 8'hF7, 8'h00, 8'h08);
        expect_ev(k, D + 3, 8'h77, 8'h00, 8'h80);
        in_raw[3] = 1'b0;
        cycles(2);
        in_raw[7] = 1'b0;
        cycles(12);
        checks++;
        if (db_out !== 8'h77) begin
            errors++;
            $display("FAIL indep_level: got %h expected 77", db_out);
        end
        expect_ev(edge_cnt + 1, D + 1, 8'hFF, 8'h88, 8'h00);
        in_raw = 8'hFF;
        cycles(10);
        expect_ev(edge_cnt + 1, D + 1, 8'h00, 8'h00, 8'hFF);
        in_raw = 8'h00;
        cycles(10);
        expect_ev(edge_cnt + 1, D + 1, 8'hFF, 8'hFF, 8'h00);
        in_raw = 8'hFF;
        cycles(10);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL indep_missing: got none expected edge %0d db %h rise %h fall %h",
                         e.edge_n, e.db, e.rise, e.fall);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL indep_event: got edge %0d db %h rise %h fall %h expected edge %0d db %h rise %h fall %h",
                             o.edge_n, o.db, o.rise, o.fall, e.edge_n, e.db, e.rise, e.fall);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL indep_extra: got %0d extra events expected 0", obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_reset_mid_count();
        ev_t e;
        ev_t o;
        in_raw[4] = 1'b0;
        cycles(3);
        reset_n = 1'b0;
        cycles(1);
        checks++;
        if (db_out[4] !== 1'b1) begin
            errors++;
            $display("FAIL midreset_level: got %b expected 1", db_out[4]);
        end
        cycles(1);
        expect_ev(edge_cnt + 1, D + 1, 8'hEF, 8'h00, 8'h10);
        reset_n = 1'b1;
        cycles(12);
        checks++;
        if (db_out !== 8'hEF) begin
            errors++;
            $display("FAIL midreset_after: got %h expected ef", db_out);
        end
        expect_ev(edge_cnt + 1, D + 1, 8'hFF, 8'h10, 8'h00);
        in_raw[4] = 1'b1;
        cycles(10);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL midreset_missing: got none expected edge %0d db %h rise %h fall %h",
                         e.edge_n, e.db, e.rise, e.fall);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL midreset_event: got edge %0d db %h rise %h fall %h expected edge %0d db %h rise %h fall %h",
                             o.edge_n, o.db, o.rise, o.fall, e.edge_n, e.db, e.rise, e.fall);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL midreset_extra: got %0d extra events expected 0", obs_q.size());
        end
        obs_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_clean_press();
        test_glitch();
        test_bounce();
        test_independence();
        test_reset_mid_count();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
